bus_interconnect: RTL and testbench

Parametrised successor to the fixed two-slave CPU bus decoder: one CPU master fans out to NUM_SLV memory-mapped slaves.
- Each slave is selected by a programmable base/mask window.
- Slaves respond through a ready handshake, so wait-states are supported.
- An unmapped address or a slave that stalls past TIMEOUT cycles returns bus_error.
- The block sits between the riscv core and data_mem, GPIO and future peripherals.

---
 rtl/bus_interconnect_if.sv | 33 +++
 rtl/bus_interconnect.sv | 171 +++++++++++++++++
 tb/tb_bus_interconnect.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_interconnect_if.sv
// rtl/bus_interconnect_if.sv - CPU-side and slave-side signal bundle for bus_interconnect
interface bus_interconnect_if #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic                        cpu_req;
    logic                        cpu_wen;
    logic [ADDR_W-1:0]           cpu_addr;
    logic [DATA_W/8-1:0]         cpu_wstrb;
    logic [DATA_W-1:0]           cpu_wdata;
    logic [DATA_W-1:0]           cpu_rdata;
    logic                        cpu_ready;
    logic                        bus_error;
    logic [NUM_SLV-1:0]          slv_sel;
    logic                        slv_wen;
    logic [ADDR_W-1:0]           slv_addr;
    logic [DATA_W/8-1:0]         slv_wstrb;
    logic [DATA_W-1:0]           slv_wdata;
    logic [NUM_SLV*DATA_W-1:0]   slv_rdata;
    logic [NUM_SLV-1:0]          slv_ready;

    // master: the interconnect itself, mastering the slave ports on behalf of the CPU
    modport master (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wstrb, cpu_wdata, slv_rdata, slv_ready,
        output cpu_rdata, cpu_ready, bus_error, slv_sel, slv_wen, slv_addr, slv_wstrb, slv_wdata
    );

    modport slave (
        output cpu_req, cpu_wen, cpu_addr, cpu_wstrb, cpu_wdata, slv_rdata, slv_ready,
        input  cpu_rdata, cpu_ready, bus_error, slv_sel, slv_wen, slv_addr, slv_wstrb, slv_wdata
    );
endinterface

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - one CPU master to NUM_SLV windowed slaves with wait-states and timeout
// Optional macro BUS_ERR_LOG_EN adds err_addr/err_cnt error logging ports.
module bus_interconnect #(
    parameter int                        NUM_SLV  = 4,
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hFFFF_F000}},
    parameter int                        TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_interconnect_if.master bus
`ifdef BUS_ERR_LOG_EN
    ,
    output logic [ADDR_W-1:0]  err_addr,
    output logic [7:0]         err_cnt
`endif
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;
    localparam int         SW       = DATA_W / 8;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [SW-1:0]      wstrb_q, wstrb_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;

    logic [NUM_SLV-1:0] hit_sel;
    logic [DATA_W-1:0]  sel_rdata;
    logic               sel_ready;

    // Descending scan so the lowest matching window overwrites the others
    always_comb begin
        hit_sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((bus.cpu_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = bus.slv_rdata[i*DATA_W +: DATA_W];
                sel_ready = bus.slv_ready[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        sel_d   = '0;
        cnt_d   = '0;
        rdata_d = '0;
        ready_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wen_d   = bus.cpu_wen;
                    wstrb_d = bus.cpu_wstrb;
                    wdata_d = bus.cpu_wdata;
                    if (|hit_sel) begin
                        sel_d   = hit_sel;
                        state_d = S_ACCESS;
                    end else begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_ACCESS: begin
                // Ready is checked first so it wins on the timeout cycle
                if (sel_ready) begin
                    rdata_d = wen_q ? '0 : sel_rdata;
                    ready_d = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    sel_d = sel_q;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = ready_q;
    assign bus.bus_error = error_q;
    assign bus.slv_sel   = sel_q;
    assign bus.slv_wen   = wen_q & (|sel_q);
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wstrb = wstrb_q;
    assign bus.slv_wdata = wdata_q;

`ifdef BUS_ERR_LOG_EN
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    always_comb begin
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (state_d == S_ERR) begin
            err_addr_d = addr_d;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
`endif
endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - self-checking bench for bus_interconnect (table vectors, random vs model, corner sequences)
module tb_bus_interconnect;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          lat;
        logic [3:0]  sel;
        logic        err;
        int          cyc;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic        path_ok;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int acc_cyc = 0;
    int cur_lat = 0;
    logic [31:0] sdata [NS];
    logic [31:0] win_base [NS] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    logic [31:0] win_mask = 32'hFFFF_F000;

    bus_interconnect_if #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();
    bus_interconnect_if #(.NUM_SLV(2), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

`ifdef BUS_ERR_LOG_EN
    logic [31:0] err_addr, err_addr2;
    logic [7:0]  err_cnt, err_cnt2;
    logic [31:0] exp_eaddr = '0;
    int          exp_ecnt = 0;
`endif

    bus_interconnect #(
        .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK({4{32'hFFFF_F000}}), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef BUS_ERR_LOG_EN
        , .err_addr(err_addr), .err_cnt(err_cnt)
`endif
    );

    bus_interconnect #(
        .NUM_SLV(2), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE({32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK({2{32'hFFFF_F000}}), .TIMEOUT(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef BUS_ERR_LOG_EN
        , .err_addr(err_addr2), .err_cnt(err_cnt2)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural slave farm: selected slave answers after cur_lat wait cycles, others toggle ready randomly
    task automatic step();
        logic [NS-1:0] rdy;
        @(posedge clk);
        #1;
        if (bus.slv_sel != '0) acc_cyc++;
        else acc_cyc = 0;
        rdy = NS'($urandom) & ~bus.slv_sel;
        if (bus.slv_sel != '0 && acc_cyc > cur_lat) rdy = rdy | bus.slv_sel;
        bus.slv_ready = rdy;
    endtask

    task automatic load_slaves();
        for (int i = 0; i < NS; i++) bus.slv_rdata[i*DW +: DW] = sdata[i];
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int lat, input logic [3:0] exp_sel,
                           input bit noise, output obs_t o);
        o.cyc = 0; o.err = 1'b0; o.rdata = '0; o.path_ok = 1'b1;
        cur_lat = lat;
        load_slaves();
        bus.cpu_req = 1'b1; bus.cpu_wen = wen; bus.cpu_addr = addr;
        bus.cpu_wstrb = wstrb; bus.cpu_wdata = wdata;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (bus.cpu_ready) begin
                o.cyc = c; o.err = bus.bus_error; o.rdata = bus.cpu_rdata;
                if (bus.slv_sel != '0) o.path_ok = 1'b0;
                bus.cpu_req = 1'b0;
                break;
            end
            if (bus.slv_sel != exp_sel) o.path_ok = 1'b0;
            if (bus.slv_sel != '0 && (bus.slv_wen !== wen || bus.slv_addr !== addr ||
                bus.slv_wstrb !== wstrb || bus.slv_wdata !== wdata)) o.path_ok = 1'b0;
            // Busy-time requests must be ignored and must not disturb the latched fields
            bus.cpu_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                bus.cpu_addr = $urandom; bus.cpu_wen = 1'($urandom);
                bus.cpu_wstrb = 4'($urandom); bus.cpu_wdata = $urandom;
            end
        end
        step();
        if (bus.cpu_ready !== 1'b0) o.path_ok = 1'b0;
    endtask

    function automatic int model_hit(input logic [31:0] a);
        for (int i = 0; i < NS; i++) if ((a & win_mask) == win_base[i]) return i;
        return -1;
    endfunction

    task automatic log_model(input logic e, input logic [31:0] a);
`ifdef BUS_ERR_LOG_EN
        if (e) begin
            exp_eaddr = a;
            if (exp_ecnt < 255) exp_ecnt++;
        end
        check("err_addr", 64'(err_addr), 64'(exp_eaddr));
        check("err_cnt", 64'(err_cnt), 64'(exp_ecnt));
`else
        if (e && a === 32'hx) $display("unreachable");
`endif
    endtask

    vec_t vecs [9];
    obs_t o;

    initial begin
        bus.cpu_req = 0; bus.cpu_wen = 0; bus.cpu_addr = '0; bus.cpu_wstrb = '0; bus.cpu_wdata = '0;
        bus.slv_rdata = '0; bus.slv_ready = '0;
        bus2.cpu_req = 0; bus2.cpu_wen = 0; bus2.cpu_addr = '0; bus2.cpu_wstrb = '0; bus2.cpu_wdata = '0;
        bus2.slv_rdata = '0; bus2.slv_ready = '0;
        for (int i = 0; i < NS; i++) sdata[i] = 32'hA5A5_0000 + 32'(i);

        vecs[0] = '{32'h0000_1004, 1'b0, 4'h0, 32'h0,         0,   4'b0010, 1'b0, 2,  32'hA5A5_0001};
        vecs[1] = '{32'h0000_0008, 1'b1, 4'h3, 32'h1234_5678, 3,   4'b0001, 1'b0, 5,  32'h0};
        vecs[2] = '{32'h0000_8000, 1'b0, 4'h0, 32'h0,         0,   4'b0000, 1'b1, 1,  32'h0};
        vecs[3] = '{32'h0000_2000, 1'b0, 4'h0, 32'h0,         255, 4'b0100, 1'b1, 17, 32'h0};
        vecs[4] = '{32'h0000_3FFC, 1'b0, 4'h0, 32'h0,         15,  4'b1000, 1'b0, 17, 32'hA5A5_0003};
        vecs[5] = '{32'h0000_3000, 1'b0, 4'h0, 32'h0,         16,  4'b1000, 1'b1, 17, 32'h0};
        vecs[6] = '{32'h0000_4000, 1'b1, 4'hF, 32'hCAFE_F00D, 0,   4'b0000, 1'b1, 1,  32'h0};
        vecs[7] = '{32'h0000_2ABC, 1'b1, 4'hF, 32'hDEAD_BEEF, 1,   4'b0100, 1'b0, 3,  32'h0};
        vecs[8] = '{32'h0000_0FFF, 1'b0, 4'h0, 32'h0,         2,   4'b0001, 1'b0, 4,  32'hA5A5_0000};

        repeat (3) @(posedge clk);
        #1;
        check("reset cpu_ready", 64'(bus.cpu_ready), 64'd0);
        check("reset bus_error", 64'(bus.bus_error), 64'd0);
        check("reset cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        check("reset slv_sel", 64'(bus.slv_sel), 64'd0);
        check("reset slv_fields", {bus.slv_addr, bus.slv_wdata}, 64'd0);
        check("reset slv_wen_wstrb", 64'({bus.slv_wen, bus.slv_wstrb}), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            run_txn(vecs[k].addr, vecs[k].wen, vecs[k].wstrb, vecs[k].wdata, vecs[k].lat, vecs[k].sel, 1'b0, o);
            check($sformatf("vec%0d cycle", k), 64'(o.cyc), 64'(vecs[k].cyc));
            check($sformatf("vec%0d bus_error", k), 64'(o.err), 64'(vecs[k].err));
            check($sformatf("vec%0d cpu_rdata", k), 64'(o.rdata), 64'(vecs[k].rdata));
            check($sformatf("vec%0d slave path", k), 64'(o.path_ok), 64'd1);
            log_model(vecs[k].err, vecs[k].addr);
        end

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a, wd;
            logic        w, e;
            logic [3:0]  ws, es;
            int          lat, hit, ecyc;
            logic [31:0] erd;
            for (int i = 0; i < NS; i++) sdata[i] = $urandom;
            a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FFF));
            w   = 1'($urandom); ws = 4'($urandom); wd = $urandom;
            lat = $urandom_range(0, 20);
            hit = model_hit(a);
            es  = (hit < 0) ? 4'b0000 : 4'(1 << hit);
            e   = (hit < 0) || (lat > TO);
            ecyc = (hit < 0) ? 1 : ((lat > TO) ? TO + 2 : lat + 2);
            erd = (e || w) ? 32'h0 : sdata[(hit < 0) ? 0 : hit];
            run_txn(a, w, ws, wd, lat, es, 1'b1, o);
            check($sformatf("rand%0d cycle", k), 64'(o.cyc), 64'(ecyc));
            check($sformatf("rand%0d resp", k), {31'd0, o.err, o.rdata}, {31'd0, e, erd});
            check($sformatf("rand%0d slave path", k), 64'(o.path_ok), 64'd1);
            log_model(e, a);
        end

        // Reset in the middle of a stalled access
        cur_lat = 255;
        bus.cpu_req = 1'b1; bus.cpu_wen = 1'b0; bus.cpu_addr = 32'h0000_2000;
        step();
        bus.cpu_req = 1'b0;
        check("stall sel before reset", 64'(bus.slv_sel), 64'(4'b0100));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset slv_sel", 64'(bus.slv_sel), 64'd0);
        check("async reset outputs", {31'd0, bus.cpu_ready, bus.bus_error, bus.cpu_rdata}, 64'd0);
        check("async reset slv_addr", 64'(bus.slv_addr), 64'd0);
`ifdef BUS_ERR_LOG_EN
        exp_eaddr = '0; exp_ecnt = 0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin
                step();
                if (bus.cpu_ready || bus.slv_sel != '0) seen = 1'b1;
            end
            check("no response after reset", 64'(seen), 64'd0);
        end
        for (int i = 0; i < NS; i++) sdata[i] = 32'hA5A5_0000 + 32'(i);
        run_txn(vecs[0].addr, vecs[0].wen, vecs[0].wstrb, vecs[0].wdata, vecs[0].lat, vecs[0].sel, 1'b0, o);
        check("post-reset read cycle", 64'(o.cyc), 64'd2);
        check("post-reset read data", 64'(o.rdata), 64'(32'hA5A5_0001));
        log_model(1'b0, 32'h0);

        // Overlapping windows on the second instance: slave0 must win
        bus2.slv_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
        bus2.cpu_req = 1'b1; bus2.cpu_addr = 32'h0000_0010; bus2.cpu_wen = 1'b0;
        @(posedge clk); #1;
        check("overlap sel", 64'(bus2.slv_sel), 64'(2'b01));
        bus2.cpu_addr = 32'h0000_8000; bus2.slv_ready = 2'b10;
        @(posedge clk); #1;
        check("overlap ignores busy req and other ready", 64'({bus2.slv_sel, bus2.cpu_ready}), 64'(3'b010));
        bus2.cpu_req = 1'b0; bus2.slv_ready = 2'b01;
        @(posedge clk); #1;
        check("overlap resp", {30'd0, bus2.cpu_ready, bus2.bus_error, bus2.cpu_rdata}, {30'd0, 2'b10, 32'hAAAA_0000});
        bus2.slv_ready = 2'b00;
        @(posedge clk); #1;
        check("overlap no second access", 64'({bus2.slv_sel, bus2.cpu_ready, bus2.bus_error}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
